countdown_timer: RTL

//   Loadable countdown timer (M:S.t style, tens-of-seconds / seconds / tenths);
//   the down-counting counterpart of the stopwatch count chain.

---
 rtl/countdown_timer.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Loadable M:S.t countdown timer: debounced start/pause button, 4-state FSM, BCD down-count to 00.0, then alarm.
// Latency: button action DEB_CYCLES+3 clk after raw edge; one tenth decrement every TICK_DIV clk in RUN.
// Backpressure: none; level/pulse inputs are sampled every cycle and all outputs are registered.
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_start_btn  raw start/pause button level (1 = pressed), asynchronous to i_clk
//   i_load       synchronous load strobe (level), honoured outside RUN
//   i_preset_ts  preset tens-of-seconds (clamped to 5)
//   i_preset_ss  preset seconds (clamped to 9)
//   o_ts/o_ss/o_tenths  BCD digits for the display decoders
//   o_running    high while counting
//   o_alarm      high while the alarm is sounding
module countdown_timer #(
  parameter int TICK_DIV    = 5_000_000,
  parameter int DEB_CYCLES  = 500_000,
  parameter int ALARM_TICKS = 20
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start_btn,
  input  logic       i_load,
  input  logic [2:0] i_preset_ts,
  input  logic [3:0] i_preset_ss,
  output logic [2:0] o_ts,
  output logic [3:0] o_ss,
  output logic [3:0] o_tenths,
  output logic       o_running,
  output logic       o_alarm
);

  localparam int PW = (TICK_DIV > 1)    ? $clog2(TICK_DIV)    : 1;
  localparam int DW = (DEB_CYCLES > 1)  ? $clog2(DEB_CYCLES)  : 1;
  localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES - 1);
  localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  // Button path registers
  logic          r_sync1;
  logic          r_sync2;
  logic          r_deb_level;
  logic          r_deb_prev;
  logic [DW-1:0] r_deb_cnt;

  // Timer state
  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [AW-1:0] r_alarm_cnt;
  logic [2:0]    r_ts;
  logic [3:0]    r_ss;
  logic [3:0]    r_tenths;
  logic          r_running;
  logic          r_alarm;

  // Combinational next-state
  logic          w_press;
  logic          w_tick;
  state_t        w_state_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic [AW-1:0] w_alarm_cnt_nxt;
  logic [2:0]    w_ts_nxt;
  logic [3:0]    w_ss_nxt;
  logic [3:0]    w_tenths_nxt;
  logic [2:0]    w_dec_ts;
  logic [3:0]    w_dec_ss;
  logic [3:0]    w_dec_tenths;
  logic          w_dec_zero;
  logic          w_is_zero;
  logic [2:0]    w_load_ts;
  logic [3:0]    w_load_ss;

  // ---------------------------------------------------------------------------
  // Synchronizer + debouncer. The accepted level flips only after DEB_CYCLES
  // consecutive synchronized samples disagree with it; any agreeing sample
  // restarts the count, so short glitches never reach the FSM.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_deb_level <= 1'b0;
      r_deb_prev  <= 1'b0;
      r_deb_cnt   <= '0;
    end else begin
      r_sync1    <= i_start_btn;
      r_sync2    <= r_sync1;
      r_deb_prev <= r_deb_level;
      if (r_sync2 == r_deb_level) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_MAX) begin
        r_deb_level <= r_sync2;
        r_deb_cnt   <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end
  end

  // One-cycle pulse on the debounced rising edge only; release is silent.
  assign w_press = r_deb_level & ~r_deb_prev;

  assign w_tick = ((r_state == S_RUN) || (r_state == S_ALARM)) && (r_presc == PRESC_MAX);

  assign w_is_zero = (r_ts == 3'd0) && (r_ss == 4'd0) && (r_tenths == 4'd0);

  assign w_load_ts = (i_preset_ts > 3'd5) ? 3'd5 : i_preset_ts;
  assign w_load_ss = (i_preset_ss > 4'd9) ? 4'd9 : i_preset_ss;

  // BCD borrow chain. ts is never borrowed from at 00.0 because RUN exits
  // to ALARM as soon as the value reaches zero.
  always_comb begin
    w_dec_ts     = r_ts;
    w_dec_ss     = r_ss;
    w_dec_tenths = (r_tenths == 4'd0) ? 4'd9 : r_tenths - 4'd1;
    if (r_tenths == 4'd0) begin
      w_dec_ss = (r_ss == 4'd0) ? 4'd9 : r_ss - 4'd1;
      if (r_ss == 4'd0) begin
        w_dec_ts = r_ts - 3'd1;
      end
    end
  end

  assign w_dec_zero = (w_dec_ts == 3'd0) && (w_dec_ss == 4'd0) && (w_dec_tenths == 4'd0);

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt     = r_state;
    w_presc_nxt     = r_presc;
    w_alarm_cnt_nxt = r_alarm_cnt;
    w_ts_nxt        = r_ts;
    w_ss_nxt        = r_ss;
    w_tenths_nxt    = r_tenths;

    case (r_state)
      S_IDLE: begin
        w_presc_nxt = '0;
        // Load wins over a coincident press.
        if (i_load) begin
          w_ts_nxt     = w_load_ts;
          w_ss_nxt     = w_load_ss;
          w_tenths_nxt = 4'd0;
        end else if (w_press && !w_is_zero) begin
          w_state_nxt = S_RUN;
        end
      end

      S_RUN: begin
        w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
        if (w_tick) begin
          w_ts_nxt     = w_dec_ts;
          w_ss_nxt     = w_dec_ss;
          w_tenths_nxt = w_dec_tenths;
        end
        // Reaching zero beats a coincident press; load is ignored while running.
        if (w_tick && w_dec_zero) begin
          w_state_nxt     = S_ALARM;
          w_alarm_cnt_nxt = '0;
        end else if (w_press) begin
          w_state_nxt = S_PAUSE;
        end
      end

      S_PAUSE: begin
        // Prescaler is held so the resumed tenth is only the remainder.
        if (i_load) begin
          w_state_nxt  = S_IDLE;
          w_presc_nxt  = '0;
          w_ts_nxt     = w_load_ts;
          w_ss_nxt     = w_load_ss;
          w_tenths_nxt = 4'd0;
        end else if (w_press) begin
          w_state_nxt = S_RUN;
        end
      end

      S_ALARM: begin
        w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
        if (i_load) begin
          w_state_nxt  = S_IDLE;
          w_presc_nxt  = '0;
          w_ts_nxt     = w_load_ts;
          w_ss_nxt     = w_load_ss;
          w_tenths_nxt = 4'd0;
        end else if (w_press) begin
          w_state_nxt = S_IDLE;
          w_presc_nxt = '0;
        end else if (w_tick) begin
          if (r_alarm_cnt == ALARM_MAX) begin
            w_state_nxt     = S_IDLE;
            w_alarm_cnt_nxt = '0;
          end else begin
            w_alarm_cnt_nxt = r_alarm_cnt + AW'(1);
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_presc     <= '0;
      r_alarm_cnt <= '0;
      r_ts        <= 3'd0;
      r_ss        <= 4'd0;
      r_tenths    <= 4'd0;
      r_running   <= 1'b0;
      r_alarm     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_presc     <= w_presc_nxt;
      r_alarm_cnt <= w_alarm_cnt_nxt;
      r_ts        <= w_ts_nxt;
      r_ss        <= w_ss_nxt;
      r_tenths    <= w_tenths_nxt;
      // Status flags track the state being entered so they switch on the
      // same edge as the digits.
      r_running   <= (w_state_nxt == S_RUN);
      r_alarm     <= (w_state_nxt == S_ALARM);
    end
  end

  assign o_ts      = r_ts;
  assign o_ss      = r_ss;
  assign o_tenths  = r_tenths;
  assign o_running = r_running;
  assign o_alarm   = r_alarm;

endmodule
